// File: rtl/mms_pkg.sv
// Shared MMU definitions: ITLB controller states, geometry constants and PTE flag positions.
package mms_pkg;

  localparam int MXLEN        = 64;
  localparam int ITLB_ENTRIES = 8;
  localparam int ITLB_VPN_W   = 27;

  localparam int PTE_BIT_V = 0;
  localparam int PTE_BIT_R = 1;
  localparam int PTE_BIT_W = 2;
  localparam int PTE_BIT_X = 3;
  localparam int PTE_BIT_U = 4;
  localparam int PTE_BIT_A = 6;
  localparam int PTE_BIT_D = 7;

  typedef logic [MXLEN-1:0] pte_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESP_HIT  = 3'd1,
    ST_WALK_REQ  = 3'd2,
    ST_WALK_WAIT = 3'd3,
    ST_REFILL    = 3'd4,
    ST_RESP_WALK = 3'd5,
    ST_FLUSH     = 3'd6
  } itlb_state_e;

  // An instruction fetch faults unless the leaf is valid, executable, accessed and not write-only.
  function automatic logic pte_fault(input logic err, input logic v, input logic r,
                                     input logic w, input logic x, input logic a);
    return err | ~v | ~x | ~a | (~r & w);
  endfunction

endpackage

// File: rtl/itlb_victim_sel.sv
// Picks the refill victim: lowest-index invalid line, else the round-robin pointer.
module itlb_victim_sel #(
  parameter int NUM_ENTRIES = 8,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] valid,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       victim
);

  logic [IDX_W-1:0] first_inv_s;

  // scan downwards so the lowest invalid index is the last one kept
  always_comb begin
    first_inv_s = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      first_inv_s = valid[i] ? first_inv_s : IDX_W'(i);
    end
  end

  assign victim = (&valid) ? rr_ptr : first_inv_s;

endmodule

// File: rtl/itlb_ctrl.sv
// ITLB sequencer: tag/valid store, hit lookup, PTW miss handling, victim refill and global flush.
module itlb_ctrl
  import mms_pkg::*;
#(
  parameter int NUM_ENTRIES = ITLB_ENTRIES,
  parameter int VPN_W       = ITLB_VPN_W,
  parameter int PTE_W       = MXLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  input  logic [VPN_W-1:0]         lkp_vpn_i,
  output logic                     resp_valid_o,
  output logic                     resp_miss_o,
  output logic                     resp_fault_o,
  output logic [PTE_W-1:0]         resp_pte_o,
  output logic [NUM_ENTRIES-1:0]   line_rd_en_o,
  output logic [NUM_ENTRIES-1:0]   line_wr_en_o,
  output logic [PTE_W-1:0]         line_pte_wr_o,
  input  logic [NUM_ENTRIES*PTE_W-1:0] line_pte_rd_i,
  output logic                     ptw_req_valid_o,
  input  logic                     ptw_req_ready_i,
  output logic [VPN_W-1:0]         ptw_req_vpn_o,
  input  logic                     ptw_resp_valid_i,
  input  logic [PTE_W-1:0]         ptw_resp_pte_i,
  input  logic                     ptw_resp_err_i,
  input  logic                     flush_i,
  output logic                     flush_done_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  itlb_state_e              state_r, state_s;
  logic [VPN_W-1:0]         vpn_r;
  logic [VPN_W-1:0]         tag_r [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   valid_r;
  logic [IDX_W-1:0]         idx_r, rr_ptr_r, victim_s, hit_idx_s;
  logic [NUM_ENTRIES-1:0]   match_s, idx_oh_s, victim_oh_s;
  logic [PTE_W-1:0]         pte_r, rd_or_s;
  logic                     hit_s, miss_r, fault_r, flush_pend_r, walk_fault_s, accept_s;

  assign lkp_ready_o  = (state_r == ST_IDLE) & ~flush_i & ~flush_pend_r;
  assign accept_s     = lkp_ready_o & lkp_valid_i;
  assign walk_fault_s = pte_fault(ptw_resp_err_i, ptw_resp_pte_i[PTE_BIT_V], ptw_resp_pte_i[PTE_BIT_R],
                                  ptw_resp_pte_i[PTE_BIT_W], ptw_resp_pte_i[PTE_BIT_X],
                                  ptw_resp_pte_i[PTE_BIT_A]);

  itlb_victim_sel #(.NUM_ENTRIES(NUM_ENTRIES)) u_victim_sel (
    .valid  (valid_r),
    .rr_ptr (rr_ptr_r),
    .victim (victim_s)
  );

  // compare the incoming VPN against every valid tag
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match_s[i] = valid_r[i] & (tag_r[i] == lkp_vpn_i);
    end
  end

  assign hit_s = |match_s;

  // encode the matching line; tags are unique so at most one bit is set
  always_comb begin
    hit_idx_s = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      hit_idx_s = match_s[i] ? IDX_W'(i) : hit_idx_s;
    end
  end

  // unselected ramlines return zero, so OR-ing all of them yields the selected PTE
  always_comb begin
    rd_or_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rd_or_s = rd_or_s | line_pte_rd_i[i*PTE_W +: PTE_W];
    end
  end

  // one-hot decode of the read index and the refill victim
  always_comb begin
    idx_oh_s              = '0;
    victim_oh_s           = '0;
    idx_oh_s[idx_r]       = 1'b1;
    victim_oh_s[victim_s] = 1'b1;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_i || flush_pend_r) state_s = ST_FLUSH;
        else if (lkp_valid_i)        state_s = hit_s ? ST_RESP_HIT : ST_WALK_REQ;
        else                         state_s = ST_IDLE;
      end
      ST_WALK_REQ:  state_s = ptw_req_ready_i ? ST_WALK_WAIT : ST_WALK_REQ;
      ST_WALK_WAIT: begin
        if (ptw_resp_valid_i)
          state_s = (walk_fault_s | flush_pend_r | flush_i) ? ST_RESP_WALK : ST_REFILL;
        else
          state_s = ST_WALK_WAIT;
      end
      ST_REFILL:    state_s = ST_RESP_HIT;
      ST_RESP_HIT,
      ST_RESP_WALK: state_s = (flush_pend_r | flush_i) ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:     state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    resp_valid_o    = (state_r == ST_RESP_HIT) | (state_r == ST_RESP_WALK);
    resp_miss_o     = ((state_r == ST_RESP_HIT) & miss_r) | (state_r == ST_RESP_WALK);
    resp_fault_o    = (state_r == ST_RESP_WALK) & fault_r;
    resp_pte_o      = '0;
    line_rd_en_o    = (state_r == ST_RESP_HIT) ? idx_oh_s : '0;
    line_wr_en_o    = (state_r == ST_REFILL) ? victim_oh_s : '0;
    line_pte_wr_o   = (state_r == ST_REFILL) ? pte_r : '0;
    ptw_req_valid_o = (state_r == ST_WALK_REQ);
    ptw_req_vpn_o   = (state_r == ST_WALK_REQ) ? vpn_r : '0;
    flush_done_o    = (state_r == ST_FLUSH);
    if (state_r == ST_RESP_HIT)                  resp_pte_o = rd_or_s;
    else if (state_r == ST_RESP_WALK && !fault_r) resp_pte_o = pte_r;
    else                                          resp_pte_o = '0;
  end

  // state, lookup context, tag/valid store and victim pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      vpn_r        <= '0;
      valid_r      <= '0;
      idx_r        <= '0;
      rr_ptr_r     <= '0;
      pte_r        <= '0;
      miss_r       <= 1'b0;
      fault_r      <= 1'b0;
      flush_pend_r <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) tag_r[i] <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        vpn_r  <= lkp_vpn_i;
        idx_r  <= hit_idx_s;
        miss_r <= 1'b0;
      end
      if (state_r == ST_WALK_WAIT && ptw_resp_valid_i) begin
        pte_r   <= ptw_resp_pte_i;
        fault_r <= walk_fault_s;
      end
      if (state_r == ST_REFILL) begin
        tag_r[victim_s]   <= vpn_r;
        valid_r[victim_s] <= 1'b1;
        idx_r             <= victim_s;
        miss_r            <= 1'b1;
        // only replacing a live line advances the round-robin pointer
        if (valid_r[victim_s])
          rr_ptr_r <= (rr_ptr_r == IDX_W'(NUM_ENTRIES-1)) ? '0 : rr_ptr_r + IDX_W'(1);
      end
      if (state_r == ST_FLUSH) begin
        valid_r      <= '0;
        rr_ptr_r     <= '0;
        flush_pend_r <= 1'b0;
      end else if (flush_i && state_r != ST_IDLE) begin
        flush_pend_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_itlb_ctrl.sv
// Directed scoreboard bench for itlb_ctrl with a behavioural ramline array and a scripted PTW.
module tb_itlb_ctrl;
  import mms_pkg::*;

  localparam int N  = 8;
  localparam int VW = 27;
  localparam int PW = 64;
  localparam logic [7:0] F_V = 8'h01, F_R = 8'h02, F_W = 8'h04, F_X = 8'h08, F_A = 8'h40;
  localparam logic [7:0] F_OK = F_V | F_R | F_X | F_A;

  logic            clk_i = 1'b0;
  logic            rst_i, lkp_valid_i, lkp_ready_o;
  logic [VW-1:0]   lkp_vpn_i;
  logic            resp_valid_o, resp_miss_o, resp_fault_o;
  logic [PW-1:0]   resp_pte_o;
  logic [N-1:0]    line_rd_en_o, line_wr_en_o;
  logic [PW-1:0]   line_pte_wr_o;
  logic [N*PW-1:0] line_pte_rd_i;
  logic            ptw_req_valid_o, ptw_req_ready_i;
  logic [VW-1:0]   ptw_req_vpn_o;
  logic            ptw_resp_valid_i, ptw_resp_err_i;
  logic [PW-1:0]   ptw_resp_pte_i;
  logic            flush_i, flush_done_o;

  typedef struct packed {
    logic          miss;
    logic          fault;
    logic [PW-1:0] pte;
  } resp_t;

  resp_t         exp_q[$];
  resp_t         mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] mem [N];

  itlb_ctrl #(.NUM_ENTRIES(N), .VPN_W(VW), .PTE_W(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_vpn_i(lkp_vpn_i),
    .resp_valid_o(resp_valid_o), .resp_miss_o(resp_miss_o), .resp_fault_o(resp_fault_o),
    .resp_pte_o(resp_pte_o),
    .line_rd_en_o(line_rd_en_o), .line_wr_en_o(line_wr_en_o), .line_pte_wr_o(line_pte_wr_o),
    .line_pte_rd_i(line_pte_rd_i),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i), .ptw_req_vpn_o(ptw_req_vpn_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_pte_i(ptw_resp_pte_i), .ptw_resp_err_i(ptw_resp_err_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  // ramline array: synchronous write, combinational read gated by the read enable
  always @(posedge clk_i) begin
    for (int k = 0; k < N; k++) if (line_wr_en_o[k]) mem[k] <= line_pte_wr_o;
  end
  always_comb begin
    line_pte_rd_i = '0;
    for (int k = 0; k < N; k++) line_pte_rd_i[k*PW +: PW] = line_rd_en_o[k] ? mem[k] : '0;
  end

  function automatic logic [PW-1:0] mk_pte(input logic [43:0] ppn, input logic [7:0] flags);
    return ({20'h0, ppn} << 10) | {56'h0, flags};
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk_i) begin
    if (resp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got response pte %h, required no response", resp_pte_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_miss", {63'h0, resp_miss_o}, {63'h0, mon_e.miss});
        chk("resp_fault", {63'h0, resp_fault_o}, {63'h0, mon_e.fault});
        chk("resp_pte", resp_pte_o, mon_e.pte);
      end
    end
  end

  task automatic expect_resp(input logic miss, input logic fault, input logic [PW-1:0] pte);
    resp_t r;
    r.miss  = miss;
    r.fault = fault;
    r.pte   = pte;
    exp_q.push_back(r);
  endtask

  // called at a negedge; returns at the negedge after the lookup was accepted
  task automatic issue(input logic [VW-1:0] vpn);
    int n = 0;
    while (lkp_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: lkp_ready_o stayed %b, required 1", lkp_ready_o);
    end
    lkp_valid_i = 1'b1;
    lkp_vpn_i   = vpn;
    @(negedge clk_i);
    lkp_valid_i = 1'b0;
  endtask

  task automatic do_hit(input logic [VW-1:0] vpn, input logic [PW-1:0] pte, input logic [N-1:0] exp_rd);
    expect_resp(1'b0, 1'b0, pte);
    issue(vpn);
    chk("hit_latency", {63'h0, resp_valid_o}, 64'd1);
    chk("hit_rd_en", {56'h0, line_rd_en_o}, {56'h0, exp_rd});
    chk("hit_no_ptw", {63'h0, ptw_req_valid_o}, 64'd0);
    @(negedge clk_i);
    chk("resp_pulse", {63'h0, resp_valid_o}, 64'd0);
  endtask

  task automatic do_miss(input logic [VW-1:0] vpn, input logic [PW-1:0] pte, input logic err,
                         input logic exp_fault, input logic [N-1:0] exp_wr);
    expect_resp(1'b1, exp_fault, exp_fault ? 64'h0 : pte);
    issue(vpn);
    chk("ptw_req", {ptw_req_valid_o, 36'h0, ptw_req_vpn_o}, {1'b1, 36'h0, vpn});
    @(negedge clk_i);
    chk("ptw_req_hold", {ptw_req_valid_o, 36'h0, ptw_req_vpn_o}, {1'b1, 36'h0, vpn});
    ptw_req_ready_i = 1'b1;
    @(negedge clk_i);
    ptw_req_ready_i  = 1'b0;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_pte_i   = pte;
    ptw_resp_err_i   = err;
    @(negedge clk_i);
    ptw_resp_valid_i = 1'b0;
    ptw_resp_err_i   = 1'b0;
    chk("refill_wr_en", {56'h0, line_wr_en_o}, {56'h0, exp_wr});
    if (exp_wr != '0) begin
      chk("refill_data", line_pte_wr_o, pte);
      chk("rd_wr_exclusive", {56'h0, line_rd_en_o}, 64'd0);
    end
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < N; k++) mem[k] = '0;
    rst_i = 1'b1; lkp_valid_i = 1'b0; lkp_vpn_i = '0; ptw_req_ready_i = 1'b0;
    ptw_resp_valid_i = 1'b0; ptw_resp_pte_i = '0; ptw_resp_err_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_ready", {63'h0, lkp_ready_o}, 64'd1);
    chk("reset_outputs", {63'h0, |{resp_valid_o, resp_miss_o, resp_fault_o, resp_pte_o, line_rd_en_o,
        line_wr_en_o, line_pte_wr_o, ptw_req_valid_o, ptw_req_vpn_o, flush_done_o}}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // cold miss and hit
    do_miss(27'h123, mk_pte(44'h456, F_OK), 1'b0, 1'b0, 8'h01);
    do_hit(27'h123, mk_pte(44'h456, F_OK), 8'h01);

    // fill lines 1..7, then two replacements via the round-robin pointer
    for (int i = 1; i < N; i++)
      do_miss(27'h200 + VW'(i), mk_pte(44'h500 + 44'(i), F_OK), 1'b0, 1'b0, 8'(1 << i));
    do_miss(27'h300, mk_pte(44'h600, F_OK), 1'b0, 1'b0, 8'h01);
    do_miss(27'h301, mk_pte(44'h601, F_OK), 1'b0, 1'b0, 8'h02);
    do_miss(27'h123, mk_pte(44'h456, F_OK), 1'b0, 1'b0, 8'h04);
    do_hit(27'h300, mk_pte(44'h600, F_OK), 8'h01);
    do_hit(27'h207, mk_pte(44'h507, F_OK), 8'h80);

    // faulting walks never refill
    do_miss(27'h400, mk_pte(44'h700, F_OK), 1'b1, 1'b1, 8'h00);
    do_miss(27'h401, mk_pte(44'h701, F_V | F_R | F_A), 1'b0, 1'b1, 8'h00);
    do_miss(27'h402, mk_pte(44'h702, F_V | F_W | F_X | F_A), 1'b0, 1'b1, 8'h00);

    // flush during a walk: response still delivered, refill suppressed, FLUSH follows
    expect_resp(1'b1, 1'b0, mk_pte(44'h800, F_OK));
    issue(27'h500);
    ptw_req_ready_i = 1'b1;
    @(negedge clk_i);
    ptw_req_ready_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("ready_low_pend", {63'h0, lkp_ready_o}, 64'd0);
    ptw_resp_valid_i = 1'b1;
    ptw_resp_pte_i   = mk_pte(44'h800, F_OK);
    @(negedge clk_i);
    ptw_resp_valid_i = 1'b0;
    chk("flush_no_wr", {56'h0, line_wr_en_o}, 64'd0);
    chk("ready_low_resp", {63'h0, lkp_ready_o}, 64'd0);
    @(negedge clk_i);
    chk("flush_done", {63'h0, flush_done_o}, 64'd1);
    chk("ready_low_flush", {63'h0, lkp_ready_o}, 64'd0);
    @(negedge clk_i);
    chk("flush_done_pulse", {63'h0, flush_done_o}, 64'd0);
    chk("ready_after_flush", {63'h0, lkp_ready_o}, 64'd1);
    do_miss(27'h300, mk_pte(44'h600, F_OK), 1'b0, 1'b0, 8'h01);

    // flush in IDLE wins over a simultaneous lookup
    flush_i     = 1'b1;
    lkp_valid_i = 1'b1;
    lkp_vpn_i   = 27'h300;
    #1;
    chk("ready_flush_comb", {63'h0, lkp_ready_o}, 64'd0);
    @(negedge clk_i);
    flush_i     = 1'b0;
    lkp_valid_i = 1'b0;
    chk("idle_flush_done", {63'h0, flush_done_o}, 64'd1);
    @(negedge clk_i);
    do_miss(27'h300, mk_pte(44'h600, F_OK), 1'b0, 1'b0, 8'h01);

    // reset while requesting a walk, then a stale PTW response
    issue(27'h600);
    chk("walk_req_before_rst", {63'h0, ptw_req_valid_o}, 64'd1);
    rst_i            = 1'b1;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_pte_i   = mk_pte(44'h900, F_OK);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_mid_ready", {63'h0, lkp_ready_o}, 64'd1);
    chk("rst_mid_outputs", {63'h0, |{resp_valid_o, resp_miss_o, resp_fault_o, resp_pte_o, line_rd_en_o,
        line_wr_en_o, line_pte_wr_o, ptw_req_valid_o, ptw_req_vpn_o, flush_done_o}}, 64'd0);
    @(negedge clk_i);
    ptw_resp_valid_i = 1'b0;
    chk("stale_resp_no_wr", {56'h0, line_wr_en_o}, 64'd0);
    chk("stale_resp_idle", {62'h0, ptw_req_valid_o, lkp_ready_o}, 64'd1);
    do_miss(27'h123, mk_pte(44'h456, F_OK), 1'b0, 1'b0, 8'h01);
    do_hit(27'h123, mk_pte(44'h456, F_OK), 8'h01);

    repeat (2) @(negedge clk_i);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
